// File: rtl/adder_result_collector_if.sv
// Collector bus: issue/sum input side plus the valid/ready result side and status.
// master = adder-side producer and result consumer, slave = collector.
interface adder_result_collector_if #(
  parameter int WIDTH     = 26,
  parameter int DEPTH     = 8,
  parameter int CNT_WIDTH = 16
);
  logic                     issue_valid;
  logic [WIDTH-1:0]         sum_in;
  logic                     flush;
  logic                     res_ready;
  logic                     res_valid;
  logic [WIDTH-1:0]         res_data;
  logic [$clog2(DEPTH):0]   fifo_count;
  logic                     full;
  logic [CNT_WIDTH-1:0]     drop_count;

  modport master (
    output issue_valid, sum_in, flush, res_ready,
    input  res_valid, res_data, fifo_count, full, drop_count
  );

  modport slave (
    input  issue_valid, sum_in, flush, res_ready,
    output res_valid, res_data, fifo_count, full, drop_count
  );
endinterface

// File: rtl/adder_result_collector.sv
// Collects results of a valid-less fixed-latency adder: an issue tag rides a shift register
// alongside the adder pipe and, on arrival, pushes sum_in into a FWFT FIFO with drop counting.
module adder_result_collector #(
  parameter int WIDTH     = 26,
  parameter int LATENCY   = 6,
  parameter int DEPTH     = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                    clock0,
  input  logic                    reset,
  adder_result_collector_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [LATENCY-1:0]   vld_pipe;
  logic [WIDTH-1:0]     mem [DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [AW:0]          count;
  logic [CNT_WIDTH-1:0] drops;
  logic                 push, pop, full, nonempty, wr_en, rd_en, drop;

  assign push     = vld_pipe[LATENCY-1];
  assign full     = (count == FULL_CNT);
  assign nonempty = (count != '0);
  assign pop      = nonempty && bus.res_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign wr_en    = push && (!full || pop) && !bus.flush;
  assign rd_en    = pop && !bus.flush;
  assign drop     = push && full && !pop && !bus.flush;

  always_ff @(posedge clock0 or negedge reset) begin
    if (!reset) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[0] <= bus.issue_valid && !bus.flush;
      for (int i = 1; i < LATENCY; i++)
        vld_pipe[i] <= vld_pipe[i-1] && !bus.flush;
    end
  end

  always_ff @(posedge clock0) begin
    if (wr_en) mem[wr_ptr] <= bus.sum_in;
  end

  always_ff @(posedge clock0 or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (bus.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      unique case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Saturating; flush deliberately leaves the history of losses intact.
  always_ff @(posedge clock0 or negedge reset) begin
    if (!reset)                  drops <= '0;
    else if (drop && drops != '1) drops <= drops + 1'b1;
  end

  assign bus.res_valid  = nonempty;
  assign bus.res_data   = mem[rd_ptr];
  assign bus.fifo_count = count;
  assign bus.full       = full;
  assign bus.drop_count = drops;
endmodule

// File: tb/tb_adder_result_collector.sv
// Directed bench for adder_result_collector: a cycle table for basic launches plus
// hand-written streaming, overflow, full push/pop, flush and async-reset sequences.
module tb_adder_result_collector;
  localparam int WIDTH = 26, LATENCY = 6, DEPTH = 8, CNT_WIDTH = 16;

  logic clock0 = 1'b0;
  logic reset  = 1'b0;
  int   checks = 0, failures = 0;

  adder_result_collector_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_WIDTH(CNT_WIDTH)) bus ();

  adder_result_collector #(.WIDTH(WIDTH), .LATENCY(LATENCY), .DEPTH(DEPTH), .CNT_WIDTH(CNT_WIDTH))
    dut (.clock0(clock0), .reset(reset), .bus(bus));

  always #5 clock0 = ~clock0;

  typedef struct {
    logic             issue;
    logic [WIDTH-1:0] sum;
    logic             ready;
    logic             ev;
    logic [WIDTH-1:0] ed;
    int               ec;
  } vec_t;

  vec_t tbl [20];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic issue, input logic [WIDTH-1:0] sum, input logic ready,
                       input logic fl);
    bus.issue_valid = issue;
    bus.sum_in      = sum;
    bus.res_ready   = ready;
    bus.flush       = fl;
  endtask

  task automatic setv(input int i, input logic issue, input logic [WIDTH-1:0] sum,
                      input logic ready, input logic ev, input logic [WIDTH-1:0] ed, input int ec);
    tbl[i] = '{issue, sum, ready, ev, ed, ec};
  endtask

  initial begin
    for (int i = 0; i < 20; i++) setv(i, 1'b0, '0, 1'b0, 1'b0, '0, 0);
    // single launch: issue at row 0, result on sum_in at row 6, visible at row 7
    setv(0,  1'b1, '0,         1'b0, 1'b0, '0,         0);
    setv(6,  1'b0, 26'h0000ABC, 1'b0, 1'b0, '0,         0);
    setv(7,  1'b0, '0,         1'b1, 1'b1, 26'h0000ABC, 1);
    // two back-to-back launches, consumer stalls one cycle
    setv(9,  1'b1, '0,         1'b0, 1'b0, '0,         0);
    setv(10, 1'b1, '0,         1'b0, 1'b0, '0,         0);
    setv(15, 1'b0, 26'h111,    1'b0, 1'b0, '0,         0);
    setv(16, 1'b0, 26'h222,    1'b0, 1'b1, 26'h111,    1);
    setv(17, 1'b0, '0,         1'b1, 1'b1, 26'h111,    2);
    setv(18, 1'b0, '0,         1'b1, 1'b1, 26'h222,    1);

    drive(1'b0, '0, 1'b0, 1'b0);
    #3;
    check("rst_valid", bus.res_valid, 0);
    check("rst_count", bus.fifo_count, 0);
    check("rst_full",  bus.full, 0);
    check("rst_drop",  bus.drop_count, 0);
    @(negedge clock0);
    reset = 1'b1;

    for (int i = 0; i < 20; i++) begin
      check($sformatf("tbl%0d_valid", i), bus.res_valid, tbl[i].ev);
      check($sformatf("tbl%0d_count", i), bus.fifo_count, tbl[i].ec);
      if (tbl[i].ev) check($sformatf("tbl%0d_data", i), bus.res_data, tbl[i].ed);
      drive(tbl[i].issue, tbl[i].sum, tbl[i].ready, 1'b0);
      @(negedge clock0);
    end

    // streaming: 20 launches, consumer always ready, no bubbles
    for (int c = 0; c < 28; c++) begin
      if (c >= 7 && c < 27) begin
        check("stream_valid", bus.res_valid, 1);
        check("stream_data", bus.res_data, c - 6);
      end else begin
        check("stream_idle", bus.res_valid, 0);
      end
      check("stream_count_le1", (bus.fifo_count <= 1), 1);
      drive(c < 20, (c >= 6 && c < 26) ? WIDTH'(c - 5) : '0, 1'b1, 1'b0);
      @(negedge clock0);
    end
    check("stream_drop", bus.drop_count, 0);

    // overflow: 10 results into an 8-deep FIFO with the consumer stalled
    for (int c = 0; c < 17; c++) begin
      if (c == 14) check("ovf_full_after8", bus.full, 1);
      drive(c < 10, (c >= 6 && c < 16) ? WIDTH'(26'h100 + c - 6) : '0, 1'b0, 1'b0);
      @(negedge clock0);
    end
    check("ovf_count", bus.fifo_count, 8);
    check("ovf_drop", bus.drop_count, 2);
    for (int k = 0; k < 8; k++) begin
      check("ovf_drain", bus.res_data, 26'h100 + k);
      drive(1'b0, '0, 1'b1, 1'b0);
      @(negedge clock0);
    end
    check("ovf_empty", bus.res_valid, 0);

    // full with simultaneous push and pop: no drop, occupancy stays at DEPTH
    for (int c = 0; c < 15; c++) begin
      if (c == 14) check("pp_full_before", bus.full, 1);
      drive(c < 9, (c == 14) ? 26'h2AA : ((c >= 6 && c < 14) ? WIDTH'(26'h200 + c - 6) : '0),
            c == 14, 1'b0);
      @(negedge clock0);
    end
    check("pp_count", bus.fifo_count, 8);
    check("pp_drop", bus.drop_count, 2);
    for (int k = 0; k < 8; k++) begin
      check("pp_drain", bus.res_data, (k == 7) ? 26'h2AA : 26'h201 + k);
      drive(1'b0, '0, 1'b1, 1'b0);
      @(negedge clock0);
    end
    check("pp_empty", bus.res_valid, 0);

    // flush with 4 stored entries and 3 tags in flight
    for (int c = 0; c < 11; c++) begin
      if (c == 10) check("fl_count_before", bus.fifo_count, 4);
      drive(c < 7, 26'h3F0 + WIDTH'(c), 1'b0, c == 10);
      @(negedge clock0);
    end
    check("fl_count", bus.fifo_count, 0);
    for (int c = 0; c < 4; c++) begin
      check("fl_no_valid", bus.res_valid, 0);
      drive(1'b0, 26'h3FF, 1'b0, 1'b0);
      @(negedge clock0);
    end
    check("fl_drop_kept", bus.drop_count, 2);

    // asynchronous reset between edges with data stored
    for (int c = 0; c < 10; c++) begin
      drive(c < 3, 26'h500 + WIDTH'(c), 1'b0, 1'b0);
      @(negedge clock0);
    end
    check("ar_count_before", bus.fifo_count, 3);
    #2 reset = 1'b0;
    #1;
    check("ar_valid", bus.res_valid, 0);
    check("ar_count", bus.fifo_count, 0);
    check("ar_drop", bus.drop_count, 0);
    @(negedge clock0);
    reset = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("ar_lat%0d", k), bus.res_valid, k == 7);
      if (k == 7) check("ar_data", bus.res_data, 26'h3C3C3);
      drive(k == 0, (k == 6) ? 26'h3C3C3 : '0, 1'b0, 1'b0);
      @(negedge clock0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
